// File: rtl/ddr3_dfi_pkg.sv
// rtl/ddr3_dfi_pkg.sv - DFI command encodings, error codes and calibration states
package ddr3_dfi_pkg;

  // Command code is {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQC = 3'b110,
    CMD_NOP = 3'b111
  } dfi_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CLOSED   = 3'd1,
    ERR_ACT_OPEN = 3'd2,
    ERR_WQ_OVF   = 3'd3,
    ERR_RQ_OVF   = 3'd4,
    ERR_RD_EMPTY = 3'd5,
    ERR_WR_EMPTY = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    CAL_IDLE  = 2'd0,
    CAL_COUNT = 2'd1,
    CAL_DONE  = 2'd2
  } cal_state_e;

endpackage

// File: rtl/ddr3_dfi_loopback_if.sv
// rtl/ddr3_dfi_loopback_if.sv - DFI command, write-data, read-data and status bundle
interface ddr3_dfi_loopback_if #(
  parameter int DDR_ROW_BITS = 15,
  parameter int DFI_DQ_WIDTH = 32,
  parameter int DFI_DM_WIDTH = 4
);
  logic                    dfi_rst_ni;
  logic                    dfi_cke_i;
  logic                    dfi_cs_ni;
  logic                    dfi_ras_ni;
  logic                    dfi_cas_ni;
  logic                    dfi_we_ni;
  logic                    dfi_odt_i;
  logic [2:0]              dfi_bank_i;
  logic [DDR_ROW_BITS-1:0] dfi_addr_i;
  logic                    dfi_wstb_i;
  logic                    dfi_wren_i;
  logic [DFI_DM_WIDTH-1:0] dfi_mask_i;
  logic [DFI_DQ_WIDTH-1:0] dfi_data_i;
  logic                    dfi_rden_i;
  logic                    dfi_rvld_o;
  logic                    dfi_last_o;
  logic [DFI_DQ_WIDTH-1:0] dfi_data_o;
  logic                    dfi_align_i;
  logic                    dfi_calib_o;
  logic                    err_o;
  logic [2:0]              err_code_o;

  modport master (
    output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
    output dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i,
    output dfi_rden_i, dfi_align_i,
    input  dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o, err_o, err_code_o
  );

  modport slave (
    input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
    input  dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i,
    input  dfi_rden_i, dfi_align_i,
    output dfi_rvld_o, dfi_last_o, dfi_data_o, dfi_calib_o, err_o, err_code_o
  );
endinterface

// File: rtl/dfi_addr_fifo.sv
// rtl/dfi_addr_fifo.sv - 4-deep burst base-address queue; a push on a full queue
// is accepted only when a pop happens in the same cycle, otherwise dropped
module dfi_addr_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ddr3_dfi_loopback.sv
// rtl/ddr3_dfi_loopback.sv - DFI-side PHY+DRAM stand-in with on-chip burst RAM.
// Optional protocol checking: DFI_LOOPBACK_CHECK_EN
module ddr3_dfi_loopback
  import ddr3_dfi_pkg::*;
#(
  parameter int DDR_ROW_BITS = 15,
  parameter int DDR_COL_BITS = 10,
  parameter int DFI_DQ_WIDTH = 32,
  parameter int DFI_DM_WIDTH = 4,
  parameter int BEATS        = 4,
  parameter int MEM_ABITS    = 10,
  parameter int PHY_RD_DELAY = 1,
  parameter int CALIB_CYCLES = 16
) (
  input logic                clock,
  input logic                reset,
  ddr3_dfi_loopback_if.slave dfi
);
  localparam int CSB     = DDR_COL_BITS - 1;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int CAL_W   = $clog2(CALIB_CYCLES + 1);
  localparam int FULL_AW = DDR_ROW_BITS + DDR_COL_BITS + 2;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  logic [2:0]              cmd;
  logic                    cmd_valid;
  logic                    is_act, is_rd, is_wr;
  logic [DDR_ROW_BITS-1:0] row_q [8];
  logic [FULL_AW-1:0]      full_addr;
  logic [MEM_ABITS-1:0]    base;

  assign cmd       = {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni};
  assign cmd_valid = dfi.dfi_cke_i && !dfi.dfi_cs_ni && dfi.dfi_rst_ni;
  assign is_act    = cmd_valid && (cmd == CMD_ACT);
  assign is_rd     = cmd_valid && (cmd == CMD_RD);
  assign is_wr     = cmd_valid && (cmd == CMD_WR);
  assign full_addr = {dfi.dfi_bank_i, row_q[dfi.dfi_bank_i], dfi.dfi_addr_i[CSB:3], 2'b00};
  assign base      = full_addr[MEM_ABITS-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else if (is_act) begin
      row_q[dfi.dfi_bank_i] <= dfi.dfi_addr_i;
    end
  end

  logic [MEM_ABITS-1:0] wq_head, rq_head;
  logic                 wq_full, wq_empty, rq_full, rq_empty;
  logic                 wr_go, rd_go, wq_pop, rq_pop;
  logic [BEAT_W-1:0]    wr_beat, rd_beat;

  assign wr_go  = dfi.dfi_wren_i && !wq_empty;
  assign rd_go  = dfi.dfi_rden_i && !rq_empty;
  assign wq_pop = wr_go && (wr_beat == BEAT_LAST);
  assign rq_pop = rd_go && (rd_beat == BEAT_LAST);

  dfi_addr_fifo #(.WIDTH(MEM_ABITS)) u_wq (
    .clock(clock), .reset(reset), .clear(!dfi.dfi_rst_ni),
    .push(is_wr), .push_data(base), .pop(wq_pop),
    .head(wq_head), .full(wq_full), .empty(wq_empty)
  );

  dfi_addr_fifo #(.WIDTH(MEM_ABITS)) u_rq (
    .clock(clock), .reset(reset), .clear(!dfi.dfi_rst_ni),
    .push(is_rd), .push_data(base), .pop(rq_pop),
    .head(rq_head), .full(rq_full), .empty(rq_empty)
  );

  always_ff @(posedge clock) begin
    if (reset || !dfi.dfi_rst_ni) begin
      wr_beat <= '0;
      rd_beat <= '0;
    end else begin
      if (wr_go) wr_beat <= (wr_beat == BEAT_LAST) ? '0 : wr_beat + 1'b1;
      if (rd_go) rd_beat <= (rd_beat == BEAT_LAST) ? '0 : rd_beat + 1'b1;
    end
  end

  // Burst RAM: byte-masked write, write-first bypass into the registered read
  logic [DFI_DQ_WIDTH-1:0] ram [2**MEM_ABITS];
  logic [MEM_ABITS-1:0]    wr_addr, rd_addr;
  logic [DFI_DQ_WIDTH-1:0] rd_word;

  assign wr_addr = wq_head + {{(MEM_ABITS-BEAT_W){1'b0}}, wr_beat};
  assign rd_addr = rq_head + {{(MEM_ABITS-BEAT_W){1'b0}}, rd_beat};

  always_ff @(posedge clock) begin
    if (wr_go) begin
      for (int i = 0; i < DFI_DM_WIDTH; i++)
        if (!dfi.dfi_mask_i[i]) ram[wr_addr][8*i +: 8] <= dfi.dfi_data_i[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = ram[rd_addr];
    if (wr_go && (wr_addr == rd_addr)) begin
      for (int i = 0; i < DFI_DM_WIDTH; i++)
        if (!dfi.dfi_mask_i[i]) rd_word[8*i +: 8] = dfi.dfi_data_i[8*i +: 8];
    end
  end

  // Stage 0 doubles as the RAM output register
  logic                    vld_sr  [PHY_RD_DELAY];
  logic                    last_sr [PHY_RD_DELAY];
  logic [DFI_DQ_WIDTH-1:0] data_sr [PHY_RD_DELAY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHY_RD_DELAY; i++) begin
        vld_sr[i]  <= 1'b0;
        last_sr[i] <= 1'b0;
        data_sr[i] <= '0;
      end
    end else begin
      for (int i = PHY_RD_DELAY - 1; i > 0; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
      vld_sr[0]  <= dfi.dfi_rden_i;
      last_sr[0] <= rq_pop;
      data_sr[0] <= rd_go ? rd_word : '0;
    end
  end

  assign dfi.dfi_rvld_o = vld_sr[PHY_RD_DELAY-1];
  assign dfi.dfi_last_o = last_sr[PHY_RD_DELAY-1];
  assign dfi.dfi_data_o = data_sr[PHY_RD_DELAY-1];

  cal_state_e       cal_q, cal_d;
  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      cal_q     <= CAL_IDLE;
      cal_cnt_q <= '0;
    end else begin
      cal_q     <= cal_d;
      cal_cnt_q <= cal_cnt_d;
    end
  end

  always_comb begin
    cal_d     = cal_q;
    cal_cnt_d = cal_cnt_q;
    case (cal_q)
      CAL_IDLE: begin
        if (dfi.dfi_align_i) begin
          cal_d     = (CALIB_CYCLES <= 1) ? CAL_DONE : CAL_COUNT;
          cal_cnt_d = CAL_W'(1);
        end
      end
      CAL_COUNT: begin
        if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) cal_d = CAL_DONE;
        else cal_cnt_d = cal_cnt_q + 1'b1;
      end
      default: cal_d = CAL_DONE;
    endcase
  end

  assign dfi.dfi_calib_o = (cal_q == CAL_DONE);

`ifdef DFI_LOOPBACK_CHECK_EN
  logic [7:0] open_q;
  logic       is_pre;
  err_code_e  err_q, err_now;

  assign is_pre = cmd_valid && (cmd == CMD_PRE);

  always_ff @(posedge clock) begin
    if (reset || !dfi.dfi_rst_ni) begin
      open_q <= '0;
    end else if (is_act) begin
      open_q[dfi.dfi_bank_i] <= 1'b1;
    end else if (is_pre) begin
      if (dfi.dfi_addr_i[10]) open_q <= '0;
      else open_q[dfi.dfi_bank_i] <= 1'b0;
    end
  end

  // Lowest code wins when several errors coincide
  always_comb begin
    err_now = ERR_NONE;
    if ((is_rd || is_wr) && !open_q[dfi.dfi_bank_i]) err_now = ERR_CLOSED;
    else if (is_act && open_q[dfi.dfi_bank_i])       err_now = ERR_ACT_OPEN;
    else if (is_wr && wq_full && !wq_pop)            err_now = ERR_WQ_OVF;
    else if (is_rd && rq_full && !rq_pop)            err_now = ERR_RQ_OVF;
    else if (dfi.dfi_rden_i && rq_empty)             err_now = ERR_RD_EMPTY;
    else if (dfi.dfi_wren_i && wq_empty)             err_now = ERR_WR_EMPTY;
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= ERR_NONE;
    else if (err_q == ERR_NONE) err_q <= err_now;
  end

  assign dfi.err_o      = (err_q != ERR_NONE);
  assign dfi.err_code_o = err_q;
`else
  assign dfi.err_o      = 1'b0;
  assign dfi.err_code_o = 3'd0;
`endif

  logic unused;
  assign unused = ^{dfi.dfi_wstb_i, dfi.dfi_odt_i, wq_full, rq_full};
endmodule

// File: tb/tb_ddr3_dfi_loopback.sv
// tb/tb_ddr3_dfi_loopback.sv - directed bench for ddr3_dfi_loopback
module tb_ddr3_dfi_loopback;
  import ddr3_dfi_pkg::*;

  localparam int RD_DLY = 3;
`ifdef DFI_LOOPBACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] got_data [32];
  logic        got_last [32];
  int          got_n, first_i, last_i;

  always #5 clock = ~clock;

  ddr3_dfi_loopback_if #(.DDR_ROW_BITS(15), .DFI_DQ_WIDTH(32), .DFI_DM_WIDTH(4)) dfi_bus ();

  ddr3_dfi_loopback #(
    .PHY_RD_DELAY(RD_DLY),
    .CALIB_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dfi(dfi_bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] code, input logic [2:0] b, input logic [14:0] a);
    dfi_bus.dfi_cs_ni = 1'b0;
    {dfi_bus.dfi_ras_ni, dfi_bus.dfi_cas_ni, dfi_bus.dfi_we_ni} = code;
    dfi_bus.dfi_bank_i = b;
    dfi_bus.dfi_addr_i = a;
    tick();
    dfi_bus.dfi_cs_ni = 1'b1;
    {dfi_bus.dfi_ras_ni, dfi_bus.dfi_cas_ni, dfi_bus.dfi_we_ni} = 3'b111;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] m);
    dfi_bus.dfi_wren_i = 1'b1;
    dfi_bus.dfi_data_i = d;
    dfi_bus.dfi_mask_i = m;
    tick();
    dfi_bus.dfi_wren_i = 1'b0;
  endtask

  task automatic do_reads(input int n);
    got_n   = 0;
    first_i = -1;
    last_i  = -1;
    for (int i = 0; i < n + RD_DLY + 2; i++) begin
      dfi_bus.dfi_rden_i = (i < n);
      tick();
      if (dfi_bus.dfi_rvld_o && got_n < 32) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        got_data[got_n] = dfi_bus.dfi_data_o;
        got_last[got_n] = dfi_bus.dfi_last_o;
        got_n++;
      end
    end
    dfi_bus.dfi_rden_i = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    dfi_bus.dfi_rst_ni   = 1'b1;
    dfi_bus.dfi_cke_i    = 1'b1;
    dfi_bus.dfi_cs_ni    = 1'b1;
    dfi_bus.dfi_ras_ni   = 1'b1;
    dfi_bus.dfi_cas_ni   = 1'b1;
    dfi_bus.dfi_we_ni    = 1'b1;
    dfi_bus.dfi_odt_i    = 1'b0;
    dfi_bus.dfi_bank_i   = '0;
    dfi_bus.dfi_addr_i   = '0;
    dfi_bus.dfi_wstb_i   = 1'b0;
    dfi_bus.dfi_wren_i   = 1'b0;
    dfi_bus.dfi_mask_i   = '0;
    dfi_bus.dfi_data_i   = '0;
    dfi_bus.dfi_rden_i   = 1'b0;
    dfi_bus.dfi_align_i  = 1'b0;
    repeat (3) tick();

    check("rst_rvld",  {31'd0, dfi_bus.dfi_rvld_o},  32'd0);
    check("rst_last",  {31'd0, dfi_bus.dfi_last_o},  32'd0);
    check("rst_data",  dfi_bus.dfi_data_o,           32'd0);
    check("rst_calib", {31'd0, dfi_bus.dfi_calib_o}, 32'd0);
    check("rst_err",   {31'd0, dfi_bus.err_o},       32'd0);
    check("rst_code",  {29'd0, dfi_bus.err_code_o},  32'd0);
    reset = 1'b0;

    // Calibration: align for one cycle, done 16 cycles later
    dfi_bus.dfi_align_i = 1'b1;
    tick();
    dfi_bus.dfi_align_i = 1'b0;
    repeat (7) tick();
    dfi_bus.dfi_align_i = 1'b1;
    tick();
    dfi_bus.dfi_align_i = 1'b0;
    repeat (6) tick();
    check("calib_at15", {31'd0, dfi_bus.dfi_calib_o}, 32'd0);
    tick();
    check("calib_at16", {31'd0, dfi_bus.dfi_calib_o}, 32'd1);
    repeat (4) tick();
    check("calib_hold", {31'd0, dfi_bus.dfi_calib_o}, 32'd1);

    // Write/read round trip
    cmd(CMD_ACT, 3'd2, 15'h0012);
    cmd(CMD_WR,  3'd2, 15'h0008);
    for (int k = 0; k < 4; k++) wbeat(32'hA0 + k, 4'b0000);
    cmd(CMD_RD,  3'd2, 15'h0008);
    do_reads(4);
    check("rt_count", got_n, 32'd4);
    check("rt_first", first_i, RD_DLY - 1);
    check("rt_gapless", last_i, RD_DLY + 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rt_data%0d", k), got_data[k], 32'hA0 + k);
      check($sformatf("rt_last%0d", k), {31'd0, got_last[k]}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Byte masking: mask bit set keeps the old byte
    cmd(CMD_WR, 3'd2, 15'h0010);
    for (int k = 0; k < 4; k++) wbeat(32'hFFFF_FFFF, 4'b0000);
    cmd(CMD_WR, 3'd2, 15'h0010);
    for (int k = 0; k < 4; k++) wbeat(32'h1122_3344, 4'b0101);
    cmd(CMD_RD, 3'd2, 15'h0010);
    do_reads(4);
    check("mask_count", got_n, 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("mask_data%0d", k), got_data[k], 32'h11FF_33FF);
    check("mask_code", {29'd0, dfi_bus.err_code_o}, 32'd0);

    // Read-queue overflow: fifth RD dropped
    cmd(CMD_RD, 3'd2, 15'h0008);
    cmd(CMD_RD, 3'd2, 15'h0010);
    cmd(CMD_RD, 3'd2, 15'h0008);
    cmd(CMD_RD, 3'd2, 15'h0010);
    check("ovf_code_pre", {29'd0, dfi_bus.err_code_o}, 32'd0);
    cmd(CMD_RD, 3'd2, 15'h0018);
    check("ovf_err",  {31'd0, dfi_bus.err_o},      CHK ? 32'd1 : 32'd0);
    check("ovf_code", {29'd0, dfi_bus.err_code_o}, CHK ? 32'd4 : 32'd0);
    do_reads(16);
    check("ovf_count", got_n, 32'd16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_data%0d", k), got_data[k],
            ((k / 4) % 2 == 0) ? (32'hA0 + (k % 4)) : 32'h11FF_33FF);
      check($sformatf("ovf_last%0d", k), {31'd0, got_last[k]}, (k % 4 == 3) ? 32'd1 : 32'd0);
    end

    // Closed bank, then a later ACT-to-open must not overwrite the code
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_calib", {31'd0, dfi_bus.dfi_calib_o}, 32'd0);
    cmd(CMD_RD, 3'd5, 15'h0000);
    check("closed_err",  {31'd0, dfi_bus.err_o},      CHK ? 32'd1 : 32'd0);
    check("closed_code", {29'd0, dfi_bus.err_code_o}, CHK ? 32'd1 : 32'd0);
    cmd(CMD_ACT, 3'd5, 15'h0001);
    cmd(CMD_ACT, 3'd5, 15'h0001);
    check("closed_keep", {29'd0, dfi_bus.err_code_o}, CHK ? 32'd1 : 32'd0);

    // Reset one cycle after the first rden kills the in-flight beat
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd(CMD_ACT, 3'd2, 15'h0012);
    cmd(CMD_RD,  3'd2, 15'h0008);
    dfi_bus.dfi_rden_i = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dfi_bus.dfi_rden_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("mid_rvld%0d", k), {31'd0, dfi_bus.dfi_rvld_o}, 32'd0);
      check($sformatf("mid_data%0d", k), dfi_bus.dfi_data_o, 32'd0);
      check($sformatf("mid_last%0d", k), {31'd0, dfi_bus.dfi_last_o}, 32'd0);
      tick();
    end
    check("mid_err", {31'd0, dfi_bus.err_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
